// File: rtl/simon_key_schedule.sv
// Sequential Simon key schedule: latches an M-word master key, emits one round key per
// cycle into a ROUNDS-deep buffer, streams each key, and serves registered buffer reads.

module simon_key_expansion #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic [N*M-1:0] window_i,
  input  logic [6:0]     round_i,
  output logic [N-1:0]   kx_o
);

  // z sequences, first element leftmost so index 0 is the constant for round M
  localparam logic [0:61] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [0:61] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [0:61] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [0:61] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [0:61] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  localparam logic [0:61] Z_SEQ =
    (N == 16)            ? Z0 :
    (N == 24 && M == 3)  ? Z0 :
    (N == 24)            ? Z1 :
    (N == 32 && M == 3)  ? Z2 :
    (N == 32)            ? Z3 :
    (N == 48 && M == 2)  ? Z2 :
    (N == 48)            ? Z3 :
    (M == 2)             ? Z2 :
    (M == 3)             ? Z3 : Z4;

  localparam logic [6:0]   M_W = 7'(M);
  localparam logic [N-1:0] C3  = {{(N-2){1'b0}}, 2'b11};

  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int s);
    return (x >> s) | (x << (N - s));
  endfunction

  logic [N-1:0] k_load;
  logic [N-1:0] k_gen;
  logic [N-1:0] tmp;
  logic [6:0]   zi;

  always_comb begin
    k_load = window_i[N-1:0];
    for (int j = 0; j < M; j++) begin
      if (round_i == 7'(j)) k_load = window_i[N*j +: N];
    end

    // window top word is k[i-1], bottom word is k[i-M]
    tmp = ror(window_i[N*M-1 -: N], 3);
    if (M == 4) tmp = tmp ^ window_i[N +: N];
    tmp = tmp ^ ror(tmp, 1);

    zi = (round_i < M_W) ? 7'd0 : (round_i - M_W);
    if (zi >= 7'd62) zi = zi - 7'd62;

    k_gen = ~window_i[N-1:0] ^ tmp ^ C3 ^ {{(N-1){1'b0}}, Z_SEQ[zi[5:0]]};
    kx_o  = (round_i < M_W) ? k_load : k_gen;
  end

endmodule

module simon_key_schedule #(
  parameter int N      = 16,
  parameter int M      = 4,
  parameter int ROUNDS = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*M-1:0] key,
  output logic           busy,
  output logic           done,
  output logic           key_ready,
  output logic           rk_valid,
  output logic [6:0]     rk_idx,
  output logic [N-1:0]   rk_word,
  input  logic [6:0]     rk_raddr,
  output logic [N-1:0]   rk_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam int         AW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [6:0] LAST = 7'(ROUNDS - 1);
  localparam logic [6:0] R_W  = 7'(ROUNDS);
  localparam logic [6:0] M_W  = 7'(M);

  logic [1:0]     state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [N*M-1:0] window_q, window_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           key_ready_q, key_ready_d;
  logic           rk_valid_q, rk_valid_d;
  logic [6:0]     rk_idx_q, rk_idx_d;
  logic [N-1:0]   rk_word_q, rk_word_d;
  logic [N-1:0]   rk_rdata_q;
  logic           buf_we;
  logic [N-1:0]   kx;

  logic [N-1:0]   rk_buf_q [0:ROUNDS-1];

  simon_key_expansion #(.N(N), .M(M)) u_kx (
    .window_i (window_q),
    .round_i  (cnt_q),
    .kx_o     (kx)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    window_d    = window_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_ready_d = key_ready_q;
    rk_valid_d  = 1'b0;
    rk_idx_d    = rk_idx_q;
    rk_word_d   = rk_word_q;
    buf_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          window_d    = key;
          cnt_d       = 7'd0;
          key_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      S_RUN: begin
        buf_we     = !rst;
        rk_valid_d = 1'b1;
        rk_idx_d   = cnt_q;
        rk_word_d  = kx;
        // first M keys are the master words themselves; afterwards the window slides
        if (cnt_q >= M_W) window_d = {kx, window_q[N*M-1:N]};
        if (cnt_q == LAST) begin
          state_d     = S_FIN;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          key_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 7'd0;
      window_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_ready_q <= 1'b0;
      rk_valid_q  <= 1'b0;
      rk_idx_q    <= 7'd0;
      rk_word_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      window_q    <= window_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_ready_q <= key_ready_d;
      rk_valid_q  <= rk_valid_d;
      rk_idx_q    <= rk_idx_d;
      rk_word_q   <= rk_word_d;
    end
  end

  // buffer survives reset; a partial schedule stays behind after an abort
  always_ff @(posedge clk) begin
    if (buf_we) rk_buf_q[cnt_q[AW-1:0]] <= kx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_rdata_q <= '0;
    end else if (rk_raddr < R_W) begin
      rk_rdata_q <= rk_buf_q[rk_raddr[AW-1:0]];
    end else begin
      rk_rdata_q <= '0;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign rk_idx    = rk_idx_q;
  assign rk_word   = rk_word_q;
  assign rk_rdata  = rk_rdata_q;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Bench for simon_key_schedule (Simon32/64): timeline model of the schedule plus
// directed start/reset/read scenarios and a few literal round-key anchors.

module tb_simon_key_schedule;

  localparam int N  = 16;
  localparam int MW = 4;
  localparam int R  = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [63:0]   key;
  logic          busy;
  logic          done;
  logic          key_ready;
  logic          rk_valid;
  logic [6:0]    rk_idx;
  logic [15:0]   rk_word;
  logic [6:0]    rk_raddr;
  logic [15:0]   rk_rdata;

  simon_key_schedule #(.N(N), .M(MW), .ROUNDS(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .key_ready (key_ready),
    .rk_valid  (rk_valid),
    .rk_idx    (rk_idx),
    .rk_word   (rk_word),
    .rk_raddr  (rk_raddr),
    .rk_rdata  (rk_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int asserts = 0;
  int fails   = 0;
  int valid_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model: Simon key schedule from the published recurrence
  string z0_str = "11111010001001010110000111001101111101000100101011000011100110";
  logic [15:0] sched [0:71];

  function automatic logic [15:0] ror16(input logic [15:0] x, input int s);
    return (x >> s) | (x << (16 - s));
  endfunction

  function automatic void gen(input logic [63:0] k64);
    logic [15:0] t;
    for (int i = 0; i < R; i++) begin
      if (i < MW) begin
        sched[i] = k64[16*i +: 16];
      end else begin
        t = ror16(sched[i-1], 3) ^ sched[i-3];
        t = t ^ ror16(t, 1);
        sched[i] = ~sched[i-4] ^ t ^ 16'h0003 ^
                   ((z0_str.getc((i - 4) % 62) == 8'h31) ? 16'h0001 : 16'h0000);
      end
    end
  endfunction

  // timeline model: t0 is the cycle an accepted start was presented, -1 if none
  int          t0 = -1;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_exp = '0;
  logic        e_busy, e_valid, e_done, e_kr;

  always @(negedge clk) begin
    e_busy  = (t0 >= 0) && (cyc >= t0 + 1) && (cyc <= t0 + R);
    e_valid = (t0 >= 0) && (cyc >= t0 + 2) && (cyc <= t0 + R + 1);
    e_done  = (t0 >= 0) && (cyc == t0 + R + 1);
    e_kr    = (t0 >= 0) && (cyc >= t0 + R + 1);
    if (cyc >= 1) begin
      chk("busy", busy, e_busy);
      chk("rk_valid", rk_valid, e_valid);
      chk("done", done, e_done);
      chk("key_ready", key_ready, e_kr);
      if (e_valid) begin
        chk("rk_idx", rk_idx, cyc - t0 - 2);
        chk("rk_word", rk_word, sched[cyc - t0 - 2]);
      end
      if (rd_pend) chk("rk_rdata", rk_rdata, rd_exp);
      if (rk_valid) valid_cnt++;
    end
    rd_pend = 1'b0;
    if (rst) begin
      rd_pend = 1'b1;
      rd_exp  = '0;
    end else if (e_kr) begin
      rd_pend = 1'b1;
      rd_exp  = (rk_raddr < R) ? sched[rk_raddr] : 16'h0000;
    end
    if (rst) begin
      t0 = -1;
    end else if (start && (t0 < 0 || cyc >= t0 + R + 2)) begin
      t0 = cyc;
      gen(key);
    end
  end

  // driver tasks: inputs change shortly after the rising edge
  task automatic drive(input logic st, input logic r, input logic [6:0] a);
    @(posedge clk);
    #2;
    start    = st;
    rst      = r;
    rk_raddr = a;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) drive(1'b0, 1'b0, 7'd0);
  endtask

  int ts;
  int vc0;

  initial begin
    rst = 1'b1; start = 1'b0; key = 64'h1918_1110_0908_0100; rk_raddr = 7'd0;

    // model anchors for Simon32/64
    gen(64'h1918_1110_0908_0100);
    chk("model_k0", sched[0], 16'h0100);
    chk("model_k1", sched[1], 16'h0908);
    chk("model_k2", sched[2], 16'h1110);
    chk("model_k3", sched[3], 16'h1918);
    chk("model_k4", sched[4], 16'h71c3);

    drive(1'b0, 1'b1, 7'd0);
    drive(1'b0, 1'b1, 7'd0);
    drive(1'b0, 1'b0, 7'd0);
    chk("reset_busy", busy, 0);
    chk("reset_key_ready", key_ready, 0);

    // Simon32/64 golden schedule
    drive(1'b1, 1'b0, 7'd0);
    ts = cyc;
    vc0 = valid_cnt;
    run_until(ts + R + 1);
    chk("done_at_start_plus_33", done, 1);
    chk("key_ready_at_start_plus_33", key_ready, 1);
    drive(1'b0, 1'b0, 7'd0);
    chk("rk_valid_pulses", valid_cnt - vc0, R);

    // buffer reads
    drive(1'b0, 1'b0, 7'd3);
    chk("read_addr0", rk_rdata, 16'h0100);
    drive(1'b0, 1'b0, 7'd31);
    chk("read_addr3", rk_rdata, 16'h1918);
    drive(1'b0, 1'b0, 7'd40);
    chk("read_addr31", rk_rdata, sched[31]);
    drive(1'b0, 1'b0, 7'd4);
    chk("read_addr40", rk_rdata, 16'h0000);
    drive(1'b0, 1'b0, 7'd0);
    chk("read_addr4", rk_rdata, 16'h71c3);

    // reset mid-idle with start held high
    drive(1'b1, 1'b1, 7'd0);
    drive(1'b1, 1'b1, 7'd0);
    drive(1'b0, 1'b0, 7'd0);
    chk("rst_idle_busy", busy, 0);
    chk("rst_idle_done", done, 0);
    chk("rst_idle_key_ready", key_ready, 0);
    chk("rst_idle_rk_valid", rk_valid, 0);
    chk("rst_idle_rk_idx", rk_idx, 0);
    chk("rst_idle_rk_word", rk_word, 0);
    chk("rst_idle_rk_rdata", rk_rdata, 0);
    drive(1'b0, 1'b0, 7'd0);
    chk("rst_start_ignored", busy, 0);

    // start pulses during RUN (cnt=5) and FIN are ignored
    key = 64'h0123_4567_89ab_cdef;
    drive(1'b1, 1'b0, 7'd0);
    ts = cyc;
    run_until(ts + 5);
    drive(1'b1, 1'b0, 7'd0);
    run_until(ts + R);
    drive(1'b1, 1'b0, 7'd0);
    chk("fin_done", done, 1);
    drive(1'b0, 1'b0, 7'd0);
    chk("fin_start_ignored", busy, 0);

    // reset at cnt=10 aborts; fresh schedule follows with the key changing after accept
    key = 64'hdead_beef_cafe_f00d;
    drive(1'b1, 1'b0, 7'd0);
    ts = cyc;
    run_until(ts + 10);
    drive(1'b0, 1'b1, 7'd0);
    drive(1'b0, 1'b0, 7'd0);
    chk("abort_busy", busy, 0);
    chk("abort_key_ready", key_ready, 0);
    chk("abort_rk_valid", rk_valid, 0);
    run_until(cyc + 5);
    key = 64'h5a5a_0f0f_3c3c_9669;
    drive(1'b1, 1'b0, 7'd0);
    ts = cyc;
    key = ~key;
    run_until(ts + R + 1);

    // back-to-back start in the first idle cycle after FIN
    key = 64'h7e11_2233_4455_a0b1;
    drive(1'b1, 1'b0, 7'd0);
    chk("b2b_start_cycle", cyc - ts, R + 2);
    ts = cyc;
    drive(1'b0, 1'b0, 7'd0);
    chk("b2b_key_ready_drops", key_ready, 0);
    run_until(ts + R + 1);
    for (int a = 0; a < R + 4; a++) drive(1'b0, 1'b0, 7'(a));
    drive(1'b0, 1'b0, 7'd0);
    drive(1'b0, 1'b0, 7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
